// File: rtl/fb_arbiter_if.sv
// Frame-buffer arbiter bus bundle: display read path, DWT engine
// handshake and the single-port RAM port, grouped for one connection.
interface fb_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  // display pixel path
  logic              disp_active;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              end_of_frame;
  // engine sequencing and access handshake
  logic              eng_start;
  logic              eng_done;
  logic              eng_req;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic [DATA_W-1:0] eng_rdata;
  // RAM port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  disp_active, disp_addr, end_of_frame,
    input  eng_done, eng_req, eng_we, eng_addr, eng_wdata,
    input  mem_rdata,
    output disp_data, eng_start, eng_gnt, eng_rvalid, eng_rdata,
    output mem_addr, mem_we, mem_wdata
  );

  // display / engine / RAM side
  modport master (
    output disp_active, disp_addr, end_of_frame,
    output eng_done, eng_req, eng_we, eng_addr, eng_wdata,
    output mem_rdata,
    input  disp_data, eng_start, eng_gnt, eng_rvalid, eng_rdata,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: the display owns the RAM inside its visible
// window, the DWT engine gets the leftover cycles, and one engine pass
// is launched per frame after the display's end-of-frame strobe.
module fb_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int SKIP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  fb_arbiter_if.slave       bus,
  output logic              busy,
  output logic [SKIP_W-1:0] frames_skipped
);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t state, state_nxt;
  logic   start_ok;
  logic   rvalid_q;

  // An end-of-frame only launches a pass from IDLE with enable set;
  // every other strobe is counted as a skipped frame.
  assign start_ok = bus.end_of_frame & enable & (state == IDLE);

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state and start pulse; eng_done outside RUN is ignored
  always_comb begin
    state_nxt     = state;
    bus.eng_start = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = START;
      START: begin
        bus.eng_start = 1'b1;
        state_nxt     = RUN;
      end
      RUN:   if (bus.eng_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Engine only wins cycles the display leaves free, and only mid-pass.
  assign bus.eng_gnt = bus.eng_req & ~bus.disp_active & busy;

  // RAM mux: the display address is the default so the RAM never sees a
  // write unless the engine holds a grant (which excludes disp_active).
  always_comb begin
    bus.mem_addr = bus.disp_addr;
    bus.mem_we   = 1'b0;
    if (bus.eng_gnt) begin
      bus.mem_addr = bus.eng_addr;
      bus.mem_we   = bus.eng_we;
    end
  end

  assign bus.mem_wdata = bus.eng_wdata;

  // RAM data is shared; rvalid tells the engine which cycle is its own.
  assign bus.eng_rdata = bus.mem_rdata;
  assign bus.disp_data = bus.mem_rdata;

  // read return flag tracks the RAM's one-cycle latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rvalid_q <= 1'b0;
    else       rvalid_q <= bus.eng_gnt & ~bus.eng_we;
  end

  assign bus.eng_rvalid = rvalid_q;

  // saturating count of end-of-frame strobes that did not start a pass
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      frames_skipped <= '0;
    else if (bus.end_of_frame && !start_ok && !(&frames_skipped))
      frames_skipped <= frames_skipped + 1'b1;
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: a RAM model drives mem_rdata, a behavioural
// reference (pass flag, queued start, shadow memory) is compared every
// cycle, and directed vectors pin literal values.
module tb_fb_arbiter;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       busy;
  logic [7:0] frames_skipped;

  int tests = 0;
  int fails = 0;

  fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SKIP_W(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .bus            (bus),
    .busy           (busy),
    .frames_skipped (frames_skipped)
  );

  always #5 clock = ~clock;

  // Power-up RAM contents: a simple address hash.
  function automatic logic [7:0] init_val(input logic [17:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // RAM model: registered read (read-before-write), synchronous write.
  logic [7:0] ram   [DEPTH];
  bit         ram_w [DEPTH];
  logic [7:0] ram_q;
  always @(posedge clock) begin
    ram_q <= ram_w[bus.mem_addr] ? ram[bus.mem_addr] : init_val(bus.mem_addr);
    if (bus.mem_we) begin
      ram[bus.mem_addr]   <= bus.mem_wdata;
      ram_w[bus.mem_addr] <= 1'b1;
    end
  end
  assign bus.mem_rdata = ram_q;

  // Reference model, stated in terms of the rules: is a pass running,
  // is a start queued for next cycle, how many frames were skipped.
  bit         m_in_pass, m_start, m_rv, m_ok, m_g, m_starts;
  int         m_skip;
  logic [7:0] m_rd;
  logic [17:0] m_a;
  logic [7:0] shadow   [DEPTH];
  bit         shadow_w [DEPTH];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_in_pass = 0; m_start = 0; m_rv = 0; m_ok = 0; m_skip = 0;
    end else begin
      m_g  = bus.eng_req && !bus.disp_active && m_in_pass;
      m_a  = m_g ? bus.eng_addr : bus.disp_addr;
      m_rv = m_g && !bus.eng_we;
      m_rd = shadow_w[m_a] ? shadow[m_a] : init_val(m_a);
      m_ok = 1;
      if (m_g && bus.eng_we) begin
        shadow[bus.eng_addr]   = bus.eng_wdata;
        shadow_w[bus.eng_addr] = 1;
      end
      m_starts = bus.end_of_frame && enable && !m_in_pass && !m_start;
      if (bus.end_of_frame && !m_starts && m_skip < 255) m_skip++;
      m_in_pass = m_start ? 1'b1 : (m_in_pass && !bus.eng_done);
      m_start   = m_starts;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clock) begin
    if (!reset && m_ok) begin
      logic        eg;
      logic [17:0] ea;
      eg = bus.eng_req && !bus.disp_active && m_in_pass;
      ea = eg ? bus.eng_addr : bus.disp_addr;
      check("m_busy",    {31'd0, busy},           {31'd0, m_in_pass});
      check("m_start",   {31'd0, bus.eng_start},  {31'd0, m_start});
      check("m_gnt",     {31'd0, bus.eng_gnt},    {31'd0, eg});
      check("m_addr",    {14'd0, bus.mem_addr},   {14'd0, ea});
      check("m_we",      {31'd0, bus.mem_we},     {31'd0, eg && bus.eng_we});
      check("m_wdata",   {24'd0, bus.mem_wdata},  {24'd0, bus.eng_wdata});
      check("m_rvalid",  {31'd0, bus.eng_rvalid}, {31'd0, m_rv});
      check("m_skip",    {24'd0, frames_skipped}, m_skip);
      check("m_rdata",   {24'd0, bus.eng_rdata},  {24'd0, m_rd});
      check("m_dispdat", {24'd0, bus.disp_data},  {24'd0, m_rd});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic eof_pulse();
    bus.end_of_frame = 1'b1;
    step();
    bus.end_of_frame = 1'b0;
  endtask

  initial begin
    bus.disp_active = 0; bus.disp_addr = '0; bus.end_of_frame = 0;
    bus.eng_done = 0; bus.eng_req = 0; bus.eng_we = 0;
    bus.eng_addr = '0; bus.eng_wdata = '0;
    repeat (3) step();
    #1 check("rst_busy", {31'd0, busy}, 0);
    check("rst_skip", {24'd0, frames_skipped}, 0);
    check("rst_rvalid", {31'd0, bus.eng_rvalid}, 0);
    check("rst_we", {31'd0, bus.mem_we}, 0);
    reset = 0;
    enable = 1;

    // 1: start pulse one cycle after end_of_frame, RUN the cycle after
    repeat (6) step();
    eof_pulse();
    check("t1_start", {31'd0, bus.eng_start}, 1);
    check("t1_busy0", {31'd0, busy}, 0);
    step();
    check("t1_start0", {31'd0, bus.eng_start}, 0);
    check("t1_busy", {31'd0, busy}, 1);
    check("t1_skip", {24'd0, frames_skipped}, 0);

    // 2: granted reads back-to-back, then a display cycle
    bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 18'h10203;
    #1 check("t2_gnt", {31'd0, bus.eng_gnt}, 1);
    check("t2_addr", {14'd0, bus.mem_addr}, 32'h10203);
    check("t2_we", {31'd0, bus.mem_we}, 0);
    step();
    bus.eng_addr = 18'h2A0B1;
    check("t2_rv1", {31'd0, bus.eng_rvalid}, 1);
    check("t2_rd1", {24'd0, bus.eng_rdata}, 32'h01);
    step();
    bus.eng_req = 0; bus.disp_active = 1; bus.disp_addr = 18'h00777;
    check("t2_rv2", {31'd0, bus.eng_rvalid}, 1);
    check("t2_rd2", {24'd0, bus.eng_rdata}, 32'h11);
    step();
    check("t2_rv3", {31'd0, bus.eng_rvalid}, 0);
    check("t2_disp", {24'd0, bus.disp_data}, 32'h70);

    // 3: write held off by the display, lands on first free cycle
    bus.eng_req = 1; bus.eng_we = 1; bus.eng_addr = 18'h00123; bus.eng_wdata = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      #1 check("t3_gnt0", {31'd0, bus.eng_gnt}, 0);
      check("t3_we0", {31'd0, bus.mem_we}, 0);
      check("t3_addr0", {14'd0, bus.mem_addr}, 32'h00777);
      step();
    end
    bus.disp_active = 0;
    #1 check("t3_gnt", {31'd0, bus.eng_gnt}, 1);
    check("t3_we", {31'd0, bus.mem_we}, 1);
    check("t3_addr", {14'd0, bus.mem_addr}, 32'h00123);
    step();
    bus.eng_req = 0; bus.eng_we = 0;
    bus.disp_active = 1; bus.disp_addr = 18'h00123;
    step();
    bus.disp_active = 0;
    check("t3_disp", {24'd0, bus.disp_data}, 32'h5A);

    // 5: done and end_of_frame together: IDLE, skipped, no restart
    bus.eng_done = 1; bus.end_of_frame = 1;
    step();
    bus.eng_done = 0; bus.end_of_frame = 0;
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_start", {31'd0, bus.eng_start}, 0);
    check("t5_skip", {24'd0, frames_skipped}, 1);
    step();
    check("t5_nostart", {31'd0, bus.eng_start}, 0);
    eof_pulse();
    check("t5_restart", {31'd0, bus.eng_start}, 1);
    step();
    check("t5_busy2", {31'd0, busy}, 1);

    // 4: skipped-frame counting and saturation, from a fresh reset
    reset = 1; step(); reset = 0; step();
    eof_pulse(); step();
    check("t4_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 3; i++) begin
      eof_pulse();
      check("t4_nostart", {31'd0, bus.eng_start}, 0);
      step();
    end
    check("t4_skip3", {24'd0, frames_skipped}, 3);
    bus.eng_done = 1; step(); bus.eng_done = 0;
    enable = 0;
    eof_pulse();
    check("t4_dis_start", {31'd0, bus.eng_start}, 0);
    check("t4_skip4", {24'd0, frames_skipped}, 4);
    bus.end_of_frame = 1;
    repeat (300) step();
    bus.end_of_frame = 0;
    check("t4_sat", {24'd0, frames_skipped}, 255);

    // 6: asynchronous reset mid-RUN with a read in flight
    enable = 1;
    eof_pulse(); step();
    bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 18'h00042;
    step();
    #1 check("t6_rv_pre", {31'd0, bus.eng_rvalid}, 1);
    check("t6_gnt_pre", {31'd0, bus.eng_gnt}, 1);
    #1 reset = 1;
    #1 check("t6_busy", {31'd0, busy}, 0);
    check("t6_rvalid", {31'd0, bus.eng_rvalid}, 0);
    check("t6_gnt", {31'd0, bus.eng_gnt}, 0);
    check("t6_we", {31'd0, bus.mem_we}, 0);
    check("t6_skip", {24'd0, frames_skipped}, 0);
    step();
    bus.eng_req = 0;
    reset = 0;
    step();
    check("t6_idle", {31'd0, busy}, 0);
    check("t6_start", {31'd0, bus.eng_start}, 0);
    check("t6_skip2", {24'd0, frames_skipped}, 0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
